adc_sample_packer: RTL and testbench

- Write-side feeder for the 64-bit dual-clock sample FIFO. It runs in the FIFO write-clock domain.
- Accepts serial 16-bit ADC samples, round-robin over 4 channels, and packs each group of 4 into one 64-bit word.
- Drives the FIFO data and wrreq inputs and honours wrfull.
- Tracks overflow and channel-alignment errors.

---
 rtl/adc_pkg.sv | 17 +
 rtl/sat_counter.sv | 27 ++
 rtl/adc_sample_packer.sv | 171 +++++++++++++++++
 tb/tb_adc_sample_packer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC sample packer.
package adc_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int FIFO_DATA_W = 64;

  typedef logic [FIFO_DATA_W-1:0] fifo_word_t;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    PACK,
    EMIT,
    HEADER
  } packer_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; an increment coinciding
// with a clear restarts the count at one so the event is not lost.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // count register: increment wins over clear, holds at all-ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc) begin
      if (clr)
        count <= W'(1);
      else if (!(&count))
        count <= count + W'(1);
    end else if (clr) begin
      count <= '0;
    end
  end

endmodule

// File: rtl/adc_sample_packer.sv
// Packs round-robin ADC samples into 64-bit words for the write side of the
// dual-clock sample FIFO, tracking dropped words and channel misalignment.
// Optional feature macro: TIMESTAMP_HEADER_EN (timestamp header words).
module adc_sample_packer #(
  parameter int SAMPLE_W    = adc_pkg::SAMPLE_W,
  parameter int LANES       = 4,
  parameter int BLOCK_WORDS = 32,
  parameter int CNT_W       = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic                            sample_valid,
  input  logic                            sample_first,
  input  logic [SAMPLE_W-1:0]             sample_data,
  input  logic                            fifo_wrfull,
  output logic [adc_pkg::FIFO_DATA_W-1:0] fifo_data,
  output logic                            fifo_wrreq,
  output logic                            overflow,
  output logic                            sync_error,
  output logic [CNT_W-1:0]                overflow_count,
  input  logic                            clear_status
);
  import adc_pkg::*;

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  if (SAMPLE_W * LANES != FIFO_DATA_W) begin : g_bad_width
    $error("SAMPLE_W*LANES must equal 64");
  end
  if (BLOCK_WORDS < 1) begin : g_bad_block
    $error("BLOCK_WORDS must be at least 1");
  end

  packer_state_t state, state_next;
  logic [LANE_W-1:0] lane, lane_next, wr_lane;
  logic [(LANES-1)*SAMPLE_W-1:0] pack_buf;
  logic take, sync_evt, word_done, hdr_start, hdr_due, emitting, drop;

  assign emitting   = (state == EMIT) || (state == HEADER);
  assign fifo_wrreq = emitting && !fifo_wrfull;
  assign drop       = emitting && fifo_wrfull;

`ifdef TIMESTAMP_HEADER_EN
  localparam int BLK_W = $clog2(BLOCK_WORDS + 1);
  logic [63:0]      ts;
  logic [BLK_W-1:0] blk_count;
  logic             blk_last;

  assign blk_last = (blk_count == BLK_W'(BLOCK_WORDS - 1));
  // The word written during EMIT closes the block when blk_last, so a lane-0
  // sample arriving in that same cycle already belongs to a new block.
  assign hdr_due = (state == ALIGN) || ((state == EMIT) ? blk_last : (blk_count == '0));

  // free-running timestamp
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts <= '0;
    else          ts <= ts + 64'd1;
  end

  sat_counter #(.W(BLK_W)) u_blk_count (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     ((state == EMIT) && !blk_last),
    .clr     ((state == ALIGN) || ((state == EMIT) && blk_last)),
    .count   (blk_count)
  );
`else
  assign hdr_due = 1'b0;
`endif

  // state and lane registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      lane  <= '0;
    end else begin
      state <= state_next;
      lane  <= lane_next;
    end
  end

  // next-state, lane sequencing and sample acceptance strobes
  always_comb begin
    state_next = state;
    lane_next  = lane;
    wr_lane    = lane;
    take       = 1'b0;
    sync_evt   = 1'b0;
    word_done  = 1'b0;
    hdr_start  = 1'b0;
    case (state)
      IDLE: if (enable) state_next = ALIGN;
      ALIGN: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (sample_valid && sample_first) begin
          take       = 1'b1;
          wr_lane    = '0;
          lane_next  = LANE_W'(1);
          state_next = PACK;
        end
      end
      PACK, EMIT, HEADER: begin
        if (!enable) begin
          state_next = IDLE;
          lane_next  = '0;
        end else begin
          state_next = PACK;
          if (sample_valid) begin
            take = 1'b1;
            if (sample_first && lane != '0) begin
              sync_evt  = 1'b1;
              wr_lane   = '0;
              lane_next = LANE_W'(1);
            end else if (lane == LAST_LANE) begin
              word_done  = 1'b1;
              lane_next  = '0;
              state_next = EMIT;
            end else begin
              lane_next = lane + 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
    hdr_start = take && (wr_lane == '0) && hdr_due;
    if (hdr_start) state_next = HEADER;
  end

  // lane buffer and FIFO data register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pack_buf  <= '0;
      fifo_data <= '0;
    end else begin
      if (take && wr_lane != LAST_LANE)
        pack_buf[wr_lane*SAMPLE_W +: SAMPLE_W] <= sample_data;
      if (word_done)
        fifo_data <= {sample_data, pack_buf};
`ifdef TIMESTAMP_HEADER_EN
      if (hdr_start)
        fifo_data <= ts;
`endif
    end
  end

  // sticky status flags: a new event wins over a simultaneous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      sync_error <= 1'b0;
    end else begin
      if (drop)              overflow <= 1'b1;
      else if (clear_status) overflow <= 1'b0;
      if (sync_evt)          sync_error <= 1'b1;
      else if (clear_status) sync_error <= 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_ovf_count (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (drop),
    .clr     (clear_status),
    .count   (overflow_count)
  );

endmodule

// File: tb/tb_adc_sample_packer.sv
// Self-checking bench for adc_sample_packer: directed scenarios followed by
// randomized traffic, compared every cycle against a queue-based sample model.
module tb_adc_sample_packer;

  localparam int BW = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic        sample_first = 1'b0;
  logic [15:0] sample_data = '0;
  logic        fifo_wrfull = 1'b0;
  logic        clear_status = 1'b0;
  logic [63:0] fifo_data;
  logic        fifo_wrreq;
  logic        overflow;
  logic        sync_error;
  logic [15:0] overflow_count;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit              m_listen, m_aligned, m_emit, m_ovf, m_sync;
  logic [15:0]     m_part[$];
  logic [63:0]     m_data;
  int unsigned     m_cnt, m_blk;
  longint unsigned m_ts;

  always #5 clk = ~clk;

  adc_sample_packer #(
    .SAMPLE_W    (16),
    .LANES       (4),
    .BLOCK_WORDS (BW),
    .CNT_W       (16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .sample_valid   (sample_valid),
    .sample_first   (sample_first),
    .sample_data    (sample_data),
    .fifo_wrfull    (fifo_wrfull),
    .fifo_data      (fifo_data),
    .fifo_wrreq     (fifo_wrreq),
    .overflow       (overflow),
    .sync_error     (sync_error),
    .overflow_count (overflow_count),
    .clear_status   (clear_status)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_listen = 0; m_aligned = 0; m_emit = 0; m_ovf = 0; m_sync = 0;
    m_part.delete(); m_data = '0; m_cnt = 0; m_blk = 0; m_ts = 0;
  endtask

  // Advance the model across one clock edge given that cycle's inputs.
  task automatic model_edge(input bit e, input bit valid, input bit first,
                            input logic [15:0] d, input bit full, input bit clr);
    bit drop, sync_ev, nxt_emit;
    drop = m_emit && full;
    sync_ev = 0;
    nxt_emit = 0;
    if (!e) begin
      m_listen = 0; m_aligned = 0; m_part.delete();
    end else if (!m_listen) begin
      m_listen = 1;
    end else if (valid && (first || m_aligned)) begin
      if (first) begin
        if (m_aligned && m_part.size() != 0) sync_ev = 1;
        if (!m_aligned) m_blk = 0;
        m_part.delete();
        m_aligned = 1;
      end
      m_part.push_back(d);
      if (m_part.size() == 4) begin
        m_data = {m_part[3], m_part[2], m_part[1], m_part[0]};
        m_part.delete();
        nxt_emit = 1;
        m_blk = (m_blk + 1) % BW;
      end
`ifdef TIMESTAMP_HEADER_EN
      else if (m_part.size() == 1 && m_blk == 0) begin
        m_data = m_ts;
        nxt_emit = 1;
      end
`endif
    end
    if (drop) begin
      m_ovf = 1;
      m_cnt = clr ? 1 : ((m_cnt == 32'd65535) ? m_cnt : m_cnt + 1);
    end else if (clr) begin
      m_ovf = 0; m_cnt = 0;
    end
    if (sync_ev) m_sync = 1;
    else if (clr) m_sync = 0;
    m_emit = nxt_emit;
    m_ts++;
  endtask

  task automatic check_outputs(input bit full);
    check("wrreq", fifo_wrreq, m_emit && !full);
    check("fifo_data", fifo_data, m_data);
    check("overflow", overflow, m_ovf);
    check("sync_error", sync_error, m_sync);
    check("overflow_count", overflow_count, m_cnt);
  endtask

  // One clock cycle: drive inputs, check mid-cycle, then step the model.
  task automatic step(input bit e, input bit valid, input bit first,
                      input logic [15:0] d, input bit full, input bit clr);
    enable = e; sample_valid = valid; sample_first = first;
    sample_data = d; fifo_wrfull = full; clear_status = clr;
    @(negedge clk);
    check_outputs(full);
    @(posedge clk);
    model_edge(e, valid, first, d, full, clr);
    #1;
  endtask

  task automatic feed(input logic [15:0] d, input bit first, input bit full);
    step(1, 1, first, d, full, 0);
  endtask

  task automatic idle(input bit full);
    step(1, 0, 0, 16'($urandom), full, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    check_outputs(fifo_wrfull);
    check("reset_wrreq", fifo_wrreq, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // alignment and packing
    idle(0); idle(0);
    feed(16'h1111, 1, 0); feed(16'h2222, 0, 0); feed(16'h3333, 0, 0); feed(16'h4444, 0, 0);
    idle(0); idle(0);
    check("first_word", fifo_data, 64'h4444_3333_2222_1111);

    // full rate
    for (int i = 1; i <= 8; i++) feed(16'(i), i == 1, 0);
    idle(0); idle(0);
    check("full_rate_word", fifo_data, 64'h0008_0007_0006_0005);

    // overflow: three words dropped, then clear
    for (int i = 0; i < 12; i++) feed(16'($urandom), i == 0, 1);
    idle(1); idle(0);
`ifndef TIMESTAMP_HEADER_EN
    check("ovf_count_3", overflow_count, 64'd3);
    check("ovf_flag", overflow, 64'd1);
`endif
    step(1, 0, 0, 16'h0, 0, 1);
    check("ovf_cleared", overflow_count, 64'd0);
    check("ovf_flag_cleared", overflow, 64'd0);

    // resync: A,B discarded, word {F,E,D,C}
    feed(16'hAAAA, 1, 0); feed(16'hBBBB, 0, 0); feed(16'hCCCC, 1, 0);
    feed(16'hDDDD, 0, 0); feed(16'hEEEE, 0, 0); feed(16'hFFFF, 0, 0);
    idle(0); idle(0);
    check("resync_word", fifo_data, 64'hFFFF_EEEE_DDDD_CCCC);
    check("resync_flag", sync_error, 64'd1);
    step(1, 0, 0, 16'h0, 0, 1);

    // reset mid-word
    feed(16'h0101, 1, 0); feed(16'h0202, 0, 0);
    do_reset();
    idle(0); idle(0);
    feed(16'h0303, 0, 0); feed(16'h0404, 0, 0);
    for (int i = 0; i < 4; i++) feed(16'h0A00 + 16'(i), i == 0, 0);
    idle(0); idle(0);

    // enable dropped mid-word
    feed(16'h0505, 1, 0); feed(16'h0606, 0, 0);
    step(0, 1, 0, 16'h0707, 0, 0);
    idle(0); idle(0);
    feed(16'h0808, 0, 0);
    for (int i = 0; i < 12; i++) feed(16'h0B00 + 16'(i), i == 0, 0);
    idle(0); idle(0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(99) != 0, $urandom_range(3) != 0, $urandom_range(15) == 0,
           16'($urandom), $urandom_range(4) == 0, $urandom_range(31) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
